// File: rtl/trafclass_sched_pkg.sv
// trafclass_sched shared types: destinations, reason codes, decision bundle
// and the priority classifier.
package trafclass_sched_pkg;

   typedef enum logic [1:0] {
      DROP     = 2'd0,
      CPU      = 2'd1,
      LOOPBACK = 2'd2,
      PASS     = 2'd3
   } dest_t;

   localparam logic [2:0] RSN_PASS    = 3'd0;
   localparam logic [2:0] RSN_CRC     = 3'd1;
   localparam logic [2:0] RSN_LEN     = 3'd2;
   localparam logic [2:0] RSN_LOOP    = 3'd3;
   localparam logic [2:0] RSN_CTRL    = 3'd4;
   localparam logic [2:0] RSN_ARP     = 3'd5;
   localparam logic [2:0] RSN_RATELIM = 3'd6;

   typedef struct packed {
      dest_t      dest;
      logic [2:0] reason;
   } dec_t;

   typedef struct packed {
      logic crc_err;
      logic len_err;
      logic usercast;
      logic broadcast;
      logic ethertype_lb;
      logic arp;
      logic ctrl;
   } flags_t;

   function automatic dec_t classify(input flags_t f, input logic lb_en);
      dec_t d;
      d = '{dest: PASS, reason: RSN_PASS};
      if (f.crc_err)
         d = '{dest: DROP, reason: RSN_CRC};
      else if (f.len_err)
         d = '{dest: DROP, reason: RSN_LEN};
      else if (f.ethertype_lb && f.usercast && lb_en)
         d = '{dest: LOOPBACK, reason: RSN_LOOP};
      else if (f.usercast && f.ctrl)
         d = '{dest: CPU, reason: RSN_CTRL};
      else if (f.broadcast && f.arp)
         d = '{dest: CPU, reason: RSN_ARP};
      return d;
   endfunction

endpackage

// File: rtl/trafclass_sched_if.sv
// Decision handshake towards the frame buffer / mux controller.
interface trafclass_sched_if;
   import trafclass_sched_pkg::*;

   logic       valid;
   logic       ready;
   dest_t      dest;
   logic [2:0] reason;

   modport master (output valid, dest, reason, input ready);
   modport slave  (input valid, dest, reason, output ready);

endinterface

// File: rtl/trafclass_tbucket.sv
// CPU punt token bucket: prescaled refill, saturating at a ceiling,
// grant evaluated against the pre-tick level.
module trafclass_tbucket #(
   parameter int TICK_DIV = 1024
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        clken_i,
   input  logic        req,
   input  logic [7:0]  rate,
   input  logic [15:0] max_lvl,
   output logic        grant,
   output logic [15:0] tokens
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] presc;
   logic          tick;
   logic          take;
   logic [15:0]   lvl;
   logic [16:0]   sum;

   assign grant = (tokens != 16'd0);
   assign take  = req && grant;
   assign tick  = (presc == PLAST);
   assign lvl   = tokens - {15'd0, take};
   assign sum   = {1'b0, lvl} + {9'd0, rate};

   // Ceiling is only enforced on refill, so a lowered max lands at the next tick.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         presc  <= '0;
         tokens <= '0;
      end else if (clken_i) begin
         presc <= tick ? '0 : presc + 1'b1;
         if (tick)
            tokens <= (sum > {1'b0, max_lvl}) ? max_lvl : sum[15:0];
         else
            tokens <= lvl;
      end
   end

endmodule

// File: rtl/trafclass_sched.sv
// Per-frame forwarding scheduler: classify at eof, rate-limit CPU punts,
// queue decisions and hand them out over a valid/ready handshake.
module trafclass_sched
   import trafclass_sched_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TICK_DIV   = 1024
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   clken_i,
   input  logic                   eof_i,
   input  logic                   crc_err_i,
   input  logic                   runt_i,
   input  logic                   oversize_i,
   input  logic                   usercast_i,
   input  logic                   broadcast_i,
   input  logic                   ethertype_lb_i,
   input  logic                   arp_i,
   input  logic                   icmp_i,
   input  logic                   telnet_i,
   input  logic                   ssh_i,
   input  logic                   dhcp_i,
   input  logic                   dns_i,
   input  logic                   et_discover_i,
   input  logic                   ptp_l2_i,
   input  logic                   ptp_l4_i,
   input  logic                   twamp_control_i,
   input  logic                   lb_en_i,
   input  logic [7:0]             punt_rate_i,
   input  logic [15:0]            bucket_max_i,
   trafclass_sched_if.master      dec,
   output logic [15:0]            ovf_cnt_o,
   output logic [15:0]            rl_drop_cnt_o,
   output logic [15:0]            tokens_o
);

   localparam int AW = $clog2(FIFO_DEPTH);

   flags_t     fl;
   dec_t       cls;
   dec_t       dec_new;
   logic       is_cpu;
   logic       punt;
   logic       grant;

   dec_t       stg;
   logic       stg_v;

   dec_t       mem [FIFO_DEPTH];
   logic [AW:0] wp;
   logic [AW:0] rp;
   logic       empty;
   logic       full;
   logic       pop;
   logic       push;
   logic       lost;

   assign fl = '{
      crc_err:      crc_err_i,
      len_err:      runt_i | oversize_i,
      usercast:     usercast_i,
      broadcast:    broadcast_i,
      ethertype_lb: ethertype_lb_i,
      arp:          arp_i,
      ctrl:         icmp_i | telnet_i | ssh_i | dhcp_i | dns_i |
                    et_discover_i | ptp_l2_i | ptp_l4_i | twamp_control_i
   };

   assign cls    = classify(fl, lb_en_i);
   assign is_cpu = (cls.dest == CPU);
   assign punt   = clken_i && eof_i && is_cpu;

   trafclass_tbucket #(
      .TICK_DIV (TICK_DIV)
   ) u_tbucket (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clken_i (clken_i),
      .req     (punt),
      .rate    (punt_rate_i),
      .max_lvl (bucket_max_i),
      .grant   (grant),
      .tokens  (tokens_o)
   );

   always_comb begin
      dec_new = cls;
      if (is_cpu && !grant)
         dec_new = '{dest: DROP, reason: RSN_RATELIM};
   end

   assign empty = (wp == rp);
   assign full  = (wp[AW] != rp[AW]) &&
                  (wp[AW-1:0] == rp[AW-1:0]);
   assign pop   = clken_i && !empty && dec.ready;
   assign push  = clken_i && stg_v && (!full || pop);
   assign lost  = clken_i && stg_v && full && !pop;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         stg_v         <= 1'b0;
         stg           <= '{dest: DROP, reason: RSN_PASS};
         wp            <= '0;
         rp            <= '0;
         ovf_cnt_o     <= '0;
         rl_drop_cnt_o <= '0;
      end else if (clken_i) begin
         stg_v <= eof_i;
         stg   <= dec_new;
         if (push)
            wp <= wp + 1'b1;
         if (pop)
            rp <= rp + 1'b1;
         if (lost && ovf_cnt_o != 16'hFFFF)
            ovf_cnt_o <= ovf_cnt_o + 1'b1;
         if (punt && !grant && rl_drop_cnt_o != 16'hFFFF)
            rl_drop_cnt_o <= rl_drop_cnt_o + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push)
         mem[wp[AW-1:0]] <= stg;
   end

   // Head is forced to DROP/0 when empty so idle outputs stay defined.
   assign dec.valid  = !empty;
   assign dec.dest   = empty ? DROP : mem[rp[AW-1:0]].dest;
   assign dec.reason = empty ? RSN_PASS : mem[rp[AW-1:0]].reason;

endmodule

// File: tb/tb_trafclass_sched.sv
// Randomized + directed bench for trafclass_sched against a queue-based
// frame-level reference model.
module tb_trafclass_sched;

   localparam int DEPTH = 4;
   localparam int TDIV  = 4;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        clken = 1'b0;
   logic        eof   = 1'b0;
   logic        lb_en = 1'b0;
   logic [15:0] fl    = '0;
   logic [7:0]  rate  = '0;
   logic [15:0] bmax  = '0;
   logic [15:0] ovf;
   logic [15:0] rl;
   logic [15:0] tok;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   trafclass_sched_if dif();

   always #5 clk = ~clk;

   trafclass_sched #(
      .FIFO_DEPTH (DEPTH),
      .TICK_DIV   (TDIV)
   ) dut (
      .clk_i           (clk),
      .rst_n_i         (rst_n),
      .clken_i         (clken),
      .eof_i           (eof),
      .crc_err_i       (fl[0]),
      .runt_i          (fl[1]),
      .oversize_i      (fl[2]),
      .usercast_i      (fl[3]),
      .broadcast_i     (fl[4]),
      .ethertype_lb_i  (fl[5]),
      .arp_i           (fl[6]),
      .icmp_i          (fl[7]),
      .telnet_i        (fl[8]),
      .ssh_i           (fl[9]),
      .dhcp_i          (fl[10]),
      .dns_i           (fl[11]),
      .et_discover_i   (fl[12]),
      .ptp_l2_i        (fl[13]),
      .ptp_l4_i        (fl[14]),
      .twamp_control_i (fl[15]),
      .lb_en_i         (lb_en),
      .punt_rate_i     (rate),
      .bucket_max_i    (bmax),
      .dec             (dif),
      .ovf_cnt_o       (ovf),
      .rl_drop_cnt_o   (rl),
      .tokens_o        (tok)
   );

   // ---------------- reference model ----------------
   int m_tok;
   int m_presc;
   int m_ovf;
   int m_rl;
   bit m_sv;
   int m_sd;
   int m_sr;
   int q_d[$];
   int q_r[$];

   function automatic void ref_cls(input logic [15:0] f, input logic lb,
                                   output int d, output int r);
      if (f[0]) begin d = 0; r = 1; end
      else if (f[1] || f[2]) begin d = 0; r = 2; end
      else if (f[5] && f[3] && lb) begin d = 2; r = 3; end
      else if (f[3] && (f[15:7] != 9'd0)) begin d = 1; r = 4; end
      else if (f[4] && f[6]) begin d = 1; r = 5; end
      else begin d = 3; r = 0; end
   endfunction

   always @(posedge clk) begin
      int d;
      int r;
      int cons;
      int nt;
      if (!rst_n) begin
         m_tok = 0; m_presc = 0; m_ovf = 0; m_rl = 0;
         m_sv = 0; m_sd = 0; m_sr = 0;
         q_d.delete(); q_r.delete();
      end else if (clken) begin
         if (q_d.size() > 0 && dif.ready) begin
            void'(q_d.pop_front());
            void'(q_r.pop_front());
         end
         if (m_sv) begin
            if (q_d.size() < DEPTH) begin
               q_d.push_back(m_sd);
               q_r.push_back(m_sr);
            end else if (m_ovf < 65535) begin
               m_ovf++;
            end
         end
         cons = 0;
         ref_cls(fl, lb_en, d, r);
         if (eof && d == 1) begin
            if (m_tok >= 1) cons = 1;
            else begin
               d = 0; r = 6;
               if (m_rl < 65535) m_rl++;
            end
         end
         m_sv = eof; m_sd = d; m_sr = r;
         m_tok = m_tok - cons;
         if (m_presc == TDIV - 1) begin
            nt = m_tok + int'(rate);
            m_tok = (nt > int'(bmax)) ? int'(bmax) : nt;
            m_presc = 0;
         end else begin
            m_presc++;
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act,
                        input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         check("m_valid", dif.valid, (q_d.size() > 0) ? 1 : 0);
         if (q_d.size() > 0) begin
            check("m_dest", dif.dest, q_d[0]);
            check("m_reason", dif.reason, q_r[0]);
         end
         check("m_tokens", tok, m_tok);
         check("m_ovf", ovf, m_ovf);
         check("m_rl", rl, m_rl);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic frame(input logic [15:0] f);
      fl  = f;
      eof = 1'b1;
      @(negedge clk);
      eof = 1'b0;
      fl  = '0;
   endtask

   task automatic pop_check(input string nm, input int d, input int r);
      check({nm, "_valid"}, dif.valid, 1);
      check({nm, "_dest"}, dif.dest, d);
      check({nm, "_reason"}, dif.reason, r);
      dif.ready = 1'b1;
      @(negedge clk);
      dif.ready = 1'b0;
   endtask

   initial begin
      dif.ready = 1'b0;
      rst_n = 1'b0;
      clken = 1'b1;
      rate  = 8'd0;
      bmax  = 16'd3;
      repeat (3) @(negedge clk);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      check("rst_valid", dif.valid, 0);
      check("rst_dest", dif.dest, 0);
      check("rst_reason", dif.reason, 0);
      check("rst_tokens", tok, 0);
      check("rst_ovf", ovf, 0);
      check("rst_rl", rl, 0);

      // crc error beats usercast
      frame(16'h0009);
      @(negedge clk);
      pop_check("crc", 0, 1);
      check("crc_tokens", tok, 0);

      // fill bucket, then punt four control frames
      rate = 8'd2;
      repeat (12) @(negedge clk);
      check("fill_tokens", tok, 3);
      rate = 8'd0;
      repeat (4) frame(16'h0088);
      @(negedge clk);
      check("rl_cnt", rl, 1);
      check("rl_tokens", tok, 0);
      pop_check("punt0", 1, 4);
      pop_check("punt1", 1, 4);
      pop_check("punt2", 1, 4);
      pop_check("punt3", 0, 6);

      // loopback enable / disable
      lb_en = 1'b1;
      frame(16'h0028);
      @(negedge clk);
      pop_check("lb_on", 2, 3);
      lb_en = 1'b0;
      frame(16'h0028);
      @(negedge clk);
      pop_check("lb_off", 3, 0);

      // overflow with ready held low
      lb_en = 1'b1;
      frame(16'h0001);
      frame(16'h0002);
      frame(16'h0028);
      frame(16'h0000);
      frame(16'h0001);
      frame(16'h0004);
      @(negedge clk);
      check("ovf_cnt", ovf, 2);
      pop_check("q0", 0, 1);
      pop_check("q1", 0, 2);
      pop_check("q2", 2, 3);
      pop_check("q3", 3, 0);
      check("q_empty", dif.valid, 0);
      lb_en = 1'b0;

      // tick coinciding with a consume at tokens=1
      rate = 8'd1;
      bmax = 16'd1;
      repeat (8) @(negedge clk);
      check("tc_pre", tok, 1);
      for (int i = 0; i < 8 && m_presc != TDIV - 1; i++)
         @(negedge clk);
      frame(16'h0088);
      check("tc_tokens", tok, 1);
      @(negedge clk);
      pop_check("tc_dec", 1, 4);

      // reset with queued decisions and clken toggling
      rate = 8'd0;
      repeat (3) frame(16'h0000);
      @(negedge clk);
      check("pre_rst_valid", dif.valid, 1);
      clken = 1'b0;
      @(negedge clk);
      clken = 1'b1;
      @(negedge clk);
      clken = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      clken = 1'b1;
      check("mr_valid", dif.valid, 0);
      check("mr_ovf", ovf, 0);
      check("mr_rl", rl, 0);
      check("mr_tokens", tok, 0);

      // randomized phase
      rate = 8'd1;
      bmax = 16'd4;
      for (int i = 0; i < 4000; i++) begin
         clken     = ($urandom_range(0, 9) != 0);
         eof       = $urandom_range(0, 1) != 0;
         fl        = 16'($urandom & $urandom);
         if ($urandom_range(0, 3) != 0)
            fl[2:0] = 3'b000;
         lb_en     = $urandom_range(0, 1) != 0;
         dif.ready = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 99) == 0) begin
            rate = 8'($urandom_range(0, 3));
            bmax = 16'($urandom_range(0, 6));
         end
         rst_n = ($urandom_range(0, 299) != 0);
         @(negedge clk);
      end
      rst_n = 1'b1;
      eof   = 1'b0;
      clken = 1'b1;
      repeat (5) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
